// File: rtl/instr_fetch_pkg.sv
// Shared types for the two-wide fetch stage: queue entry layout and FSM states.
package instr_fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // PCs are always word aligned; low two bits of any incoming target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_cache_bus_if.sv
// Request/response bundle between one fetch port and the instruction cache.
interface instr_cache_bus_if;
  import instr_fetch_pkg::*;

  logic [XLEN-1:0] address;
  logic            read;
  logic            hit;
  logic [XLEN-1:0] instr;

  modport fetch (output address, output read, input hit, input instr);
  modport cache (input address, input read, output hit, output instr);
endinterface

// File: rtl/instr_fetch_queue.sv
// Dual-push / dual-pop circular FIFO of fetch entries. A push always writes a
// full pair; up to two entries leave per cycle. Flush wins over push and pop.
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t [1:0]     push_data,
  input  logic [1:0]             pop_count,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] free,
  output fetch_entry_t [1:0]     head,
  output logic [1:0]             valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, count;
  logic [AW-1:0] rd_lo, rd_hi, wr_lo, wr_hi;

  assign rd_lo = rd_ptr[AW-1:0];
  assign rd_hi = rd_lo + AW'(1);
  assign wr_lo = wr_ptr[AW-1:0];
  assign wr_hi = wr_lo + AW'(1);

  assign head[0]  = mem[rd_lo];
  assign head[1]  = mem[rd_hi];
  assign valid[0] = (count != '0);
  assign valid[1] = (count >= PW'(2));
  assign free     = PW'(DEPTH) - count;

  // Pointer and occupancy bookkeeping; the push/pop net change lands in one step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_count);
      if (push) wr_ptr <= wr_ptr + PW'(2);
      count  <= count + (push ? PW'(2) : PW'(0)) - PW'(pop_count);
    end
  end

  // Entry storage; contents need no reset because valid comes from count.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_lo] <= push_data[0];
      mem[wr_hi] <= push_data[1];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-wide fetch stage: holds the PC, drives both cache ports with PC and
// PC+4, gathers the two hits and pushes them as an ordered pair into the
// fetch queue that the decoder drains.
//
//   state | meaning
//   IDLE  | after reset; reads low for one cycle while the cache settles
//   FETCH | request every slot not yet held, push the pair once both are held
//   STALL | queue lacks room for a pair; reads low, held slots kept
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              QUEUE_DEPTH  = 8,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  instr_cache_bus_if.fetch      cache_bus [2],
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_addr,
  output logic [1:0]            out_valid,
  input  logic [1:0]            out_ready,
  output logic [1:0][XLEN-1:0]  out_instr,
  output logic [1:0][XLEN-1:0]  out_address
);

  localparam int PW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e           state, state_next;
  logic [XLEN-1:0]        pc, pc_next;
  logic [1:0]             got, got_next;
  logic [1:0][XLEN-1:0]   hold, hold_next;

  logic [PW-1:0]          q_free, free_eff;
  logic [1:0]             q_valid, pop_n, read_v, hit_v, got_all, bus_hit;
  logic [1:0][XLEN-1:0]   bus_instr;
  fetch_entry_t [1:0]     q_head, push_data;
  logic                   room, push, take0, take1;

  assign bus_hit      = {cache_bus[1].hit, cache_bus[0].hit};
  assign bus_instr[0] = cache_bus[0].instr;
  assign bus_instr[1] = cache_bus[1].instr;

  // Slot 1 may only leave together with slot 0.
  assign take0    = q_valid[0] & out_ready[0];
  assign take1    = q_valid[1] & out_ready[1] & out_ready[0];
  assign pop_n    = {1'b0, take0} + {1'b0, take1};

  // Room is judged after this cycle's pop so a full queue can still take a pair.
  assign free_eff = q_free + PW'(pop_n);
  assign room     = (free_eff >= PW'(2));

  assign read_v   = (state == FETCH && room) ? ~got : 2'b00;
  assign hit_v    = read_v & bus_hit;
  assign got_all  = got | hit_v;
  assign push     = !redirect && (state == FETCH) && room && (got_all == 2'b11);

  assign push_data[0] = {pc, got[0] ? hold[0] : bus_instr[0]};
  assign push_data[1] = {pc + XLEN'(4), got[1] ? hold[1] : bus_instr[1]};

  assign cache_bus[0].read    = read_v[0];
  assign cache_bus[1].read    = read_v[1];
  assign cache_bus[0].address = (state == IDLE) ? '0 : pc;
  assign cache_bus[1].address = (state == IDLE) ? '0 : pc + XLEN'(4);

  assign out_valid      = q_valid;
  assign out_instr[0]   = q_head[0].instr;
  assign out_instr[1]   = q_head[1].instr;
  assign out_address[0] = q_head[0].address;
  assign out_address[1] = q_head[1].address;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop_count (pop_n),
    .flush     (redirect),
    .free      (q_free),
    .head      (q_head),
    .valid     (q_valid)
  );

  // Next-state, PC and held-slot update; redirect overrides everything.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    got_next   = got;
    hold_next  = hold;
    if (redirect) begin
      state_next = FETCH;
      pc_next    = align_word(redirect_addr);
      got_next   = 2'b00;
    end else begin
      case (state)
        IDLE: state_next = FETCH;
        FETCH: begin
          if (hit_v[0]) hold_next[0] = bus_instr[0];
          if (hit_v[1]) hold_next[1] = bus_instr[1];
          if (push) begin
            pc_next  = pc + XLEN'(8);
            got_next = 2'b00;
          end else begin
            got_next = got_all;
            if (!room && got_all != 2'b11) state_next = STALL;
          end
        end
        STALL: if (room) state_next = FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, PC and held-slot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_VECTOR;
      got   <= 2'b00;
      hold  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      got   <= got_next;
      hold  <= hold_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_instr_fetch;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;

  logic              clk;
  logic              rst_n;
  logic              redirect;
  logic [31:0]       redirect_addr;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [1:0][31:0]  out_instr;
  logic [1:0][31:0]  out_address;

  instr_cache_bus_if bus [2] ();

  instr_fetch #(.QUEUE_DEPTH(DEPTH), .RESET_VECTOR(32'h0)) dut (
    .clock         (clk),
    .reset         (rst_n),
    .cache_bus     (bus),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_address   (out_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 idle, 1 fetching, 2 stalled
  int          m_st;
  logic [31:0] m_pc;
  logic [1:0]  m_got;
  logic [31:0] m_hold [2];
  ent_t        m_q [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_pc = 32'h0;
    m_got = 2'b00;
    m_hold[0] = '0;
    m_hold[1] = '0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [1:0] rdy, input bit redir, input logic [31:0] raddr,
                            input logic [1:0] h);
    int sz, n, fe;
    logic [1:0] hv, g;
    ent_t e;
    sz = m_q.size();
    n = 0;
    if (sz >= 1 && rdy[0]) begin
      n = 1;
      if (sz >= 2 && rdy[1]) n = 2;
    end
    if (redir) begin
      m_q.delete();
      m_got = 2'b00;
      m_pc  = raddr & 32'hFFFF_FFFC;
      m_st  = 1;
      return;
    end
    repeat (n) void'(m_q.pop_front());
    fe = DEPTH - sz + n;
    case (m_st)
      0: m_st = 1;
      1: begin
        hv = (fe >= 2) ? (h & ~m_got) : 2'b00;
        if (hv[0]) m_hold[0] = f_instr(m_pc);
        if (hv[1]) m_hold[1] = f_instr(m_pc + 32'd4);
        g = m_got | hv;
        if (g == 2'b11 && fe >= 2) begin
          e.a = m_pc;          e.i = m_hold[0]; m_q.push_back(e);
          e.a = m_pc + 32'd4;  e.i = m_hold[1]; m_q.push_back(e);
          m_pc  = m_pc + 32'd8;
          m_got = 2'b00;
        end else begin
          m_got = g;
          if (fe < 2 && g != 2'b11) m_st = 2;
        end
      end
      default: if (fe >= 2) m_st = 1;
    endcase
  endtask

  // One clock: drive inputs at negedge, compare against model, answer reads, advance model.
  task automatic run_cycle(input logic [1:0] rdy, input bit redir, input logic [31:0] raddr,
                           input logic [1:0] hen, input bit hrand);
    int sz, n, fe;
    logic [1:0] rd_m, h;
    @(negedge clk);
    out_ready     = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    bus[0].hit    = 1'b0;
    bus[1].hit    = 1'b0;
    #1;
    sz = m_q.size();
    check_val("out_valid", 32'(out_valid), (sz >= 2) ? 32'd3 : (sz >= 1) ? 32'd1 : 32'd0);
    if (sz >= 1) begin
      check_val("slot0_addr",  out_address[0], m_q[0].a);
      check_val("slot0_instr", out_instr[0],   m_q[0].i);
    end
    if (sz >= 2) begin
      check_val("slot1_addr",  out_address[1], m_q[1].a);
      check_val("slot1_instr", out_instr[1],   m_q[1].i);
    end
    n = 0;
    if (sz >= 1 && rdy[0]) begin
      n = 1;
      if (sz >= 2 && rdy[1]) n = 2;
    end
    fe = DEPTH - sz + n;
    rd_m = (m_st == 1 && fe >= 2) ? ~m_got : 2'b00;
    check_val("read",  {30'b0, bus[1].read, bus[0].read}, 32'(rd_m));
    check_val("addr0", bus[0].address, (m_st == 0) ? 32'h0 : m_pc);
    check_val("addr1", bus[1].address, (m_st == 0) ? 32'h0 : m_pc + 32'd4);
    h = rd_m & (hrand ? 2'($urandom) : hen);
    bus[0].hit   = h[0];
    bus[1].hit   = h[1];
    bus[0].instr = f_instr(bus[0].address);
    bus[1].instr = f_instr(bus[1].address);
    model_step(rdy, redir, raddr, h);
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin
    logic [1:0]  hen;
    logic [31:0] ra;
    rst_n = 1'b0;
    out_ready = 2'b00;
    redirect = 1'b0;
    redirect_addr = '0;
    bus[0].hit = 1'b0;  bus[1].hit = 1'b0;
    bus[0].instr = '0;  bus[1].instr = '0;
    model_reset();
    #1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_read",  {30'b0, bus[1].read, bus[0].read}, 32'd0);
    check_val("rst_addr0", bus[0].address, 32'h0);
    check_val("rst_addr1", bus[1].address, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // always-hit start: pairs (0,4) then (8,12), then sustained one pair per cycle
    run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t1_p0_a0", out_address[0], 32'h0);
    check_val("t1_p0_a1", out_address[1], 32'h4);
    run_cycle(2'b11, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t1_p1_a0", out_address[0], 32'h8);
    check_val("t1_p1_a1", out_address[1], 32'hC);
    for (int k = 0; k < 6; k++) run_cycle(2'b11, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t1_pc_rate", bus[0].address, 32'h40);

    // staggered hits: port 0 on cycle 3, port 1 on cycle 6
    run_cycle(2'b11, 1'b1, 32'h200, 2'b00, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      hen = (k == 3) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
      run_cycle(2'b00, 1'b0, 32'h0, hen, 1'b0);
    end
    check_val("t2_valid", 32'(out_valid), 32'd3);
    check_val("t2_a0", out_address[0], 32'h200);
    check_val("t2_a1", out_address[1], 32'h204);
    check_val("t2_i1", out_instr[1], f_instr(32'h204));

    // backpressure: four pushes fill the queue, then stall
    run_cycle(2'b00, 1'b1, 32'h400, 2'b00, 1'b0);
    for (int k = 0; k < 6; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t3_stall_read", {30'b0, bus[1].read, bus[0].read}, 32'd0);
    run_cycle(2'b11, 1'b0, 32'h0, 2'b11, 1'b0);
    for (int k = 0; k < 3; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);

    // redirect to an unaligned target while six entries are queued
    run_cycle(2'b00, 1'b1, 32'h3000, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    run_cycle(2'b11, 1'b1, 32'h1003, 2'b11, 1'b0);
    check_val("t4_valid", 32'(out_valid), 32'd0);
    check_val("t4_addr0", bus[0].address, 32'h1000);
    check_val("t4_addr1", bus[1].address, 32'h1004);
    for (int k = 0; k < 2; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);

    // full queue accepts a pair when two entries leave the same cycle
    run_cycle(2'b00, 1'b1, 32'h5000, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    run_cycle(2'b11, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t5_valid", 32'(out_valid), 32'd3);
    check_val("t5_head",  out_address[0], 32'h5008);
    for (int k = 0; k < 6; k++) run_cycle(2'b11, 1'b0, 32'h0, 2'b00, 1'b0);

    // address wrap at the top of the space
    run_cycle(2'b00, 1'b1, 32'hFFFF_FFF8, 2'b00, 1'b0);
    check_val("t6_addr1_top", bus[1].address, 32'hFFFF_FFFC);
    run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    check_val("t6_wrap_pc", bus[0].address, 32'h0);
    check_val("t6_head",    out_address[0], 32'hFFFF_FFF8);

    // async reset while stalled
    for (int k = 0; k < 5; k++) run_cycle(2'b00, 1'b0, 32'h0, 2'b11, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(out_valid), 32'd0);
    check_val("arst_read",  {30'b0, bus[1].read, bus[0].read}, 32'd0);
    check_val("arst_addr0", bus[0].address, 32'h0);
    check_val("arst_addr1", bus[1].address, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                       : $urandom;
      run_cycle(2'($urandom), ($urandom_range(0, 49) == 0), ra, 2'b00, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
